// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with open-drain enables
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int ICW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ICW-1:0] INH_LAST  = ICW'(INHIBIT_CYCLES - 1);
  localparam logic [ICW-1:0] INH_HALF  = ICW'(INHIBIT_CYCLES / 2 - 1);
  localparam logic [TCW-1:0] TOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [9:0]     sh_q, sh_d;
  logic [3:0]     bitcnt_q, bitcnt_d;
  logic [ICW-1:0] icnt_q, icnt_d;
  logic [TCW-1:0] tout_q, tout_d;
  logic           clk_oe_q, clk_oe_d;
  logic           data_oe_q, data_oe_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q, fe_q;
  logic data_meta_q, data_sync_q;
  logic go_err;

  // Two-flop synchronisers on the pins plus a registered falling-edge detect of the device clock
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      fe_q        <= 1'b0;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      fe_q        <= clk_prev_q & ~clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  // State, frame, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      bitcnt_q  <= '0;
      icnt_q    <= '0;
      tout_q    <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bitcnt_q  <= bitcnt_d;
      icnt_q    <= icnt_d;
      tout_q    <= tout_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so they leave the flops
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bitcnt_d  = bitcnt_q;
    icnt_d    = icnt_q;
    tout_d    = tout_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    go_err    = 1'b0;

    // Device-clock watchdog: restarts on every falling edge while the device is clocking
    if (state_q inside {S_SHIFT, S_ACK, S_WAIT_IDLE}) begin
      if (fe_q) begin
        tout_d = '0;
      end else if (tout_q == TOUT_LAST) begin
        go_err = 1'b1;
      end else begin
        tout_d = tout_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (tx_start) begin
          sh_d     = {1'b1, ~^tx_data, tx_data};
          bitcnt_d = '0;
          icnt_d   = '0;
          tout_d   = '0;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        icnt_d = icnt_q + 1'b1;
        // Pulling DATA low halfway through the inhibit forms the start bit
        if (icnt_q == INH_HALF) data_oe_d = 1'b1;
        if (icnt_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          tout_d   = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (fe_q) begin
          data_oe_d = ~sh_q[bitcnt_q];
          bitcnt_d  = bitcnt_q + 1'b1;
          if (bitcnt_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fe_q) begin
          if (data_sync_q) go_err = 1'b1;
          else             state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
        end
      end
      S_DONE, S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Any abort releases both lines and reports through the one-cycle ERR state
    if (go_err) begin
      state_d   = S_ERR;
      err_d     = 1'b1;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
